// File: rtl/mem_pkg.sv
// Shared types for the memory access stage: size codes, FSM states, counter width.
// Optional build macro: MEM_MISALIGN_TRAP_EN (see mem_access_ctrl.sv).
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int CNT_W = 3;

  // Reserved size behaves as a full word
  function automatic logic is_word(size_e s);
    return s[1];
  endfunction

  function automatic logic is_misaligned(
    size_e      s,
    logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (s)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = lo[0];
      default: m = |lo;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request and memory-side signal bundle for mem_access_ctrl.
// master = control unit plus memory model, slave = the access stage.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              i_req;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              o_busy;
  logic              o_done;
  logic [31:0]       o_rdata;
  logic              o_misalign;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_re;
  logic              o_mem_we;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  modport master (
    output i_req,
    output i_we,
    output i_size,
    output i_unsigned,
    output i_addr,
    output i_wdata,
    output i_mem_rdata,
    input  o_busy,
    input  o_done,
    input  o_rdata,
    input  o_misalign,
    input  o_mem_addr,
    input  o_mem_re,
    input  o_mem_we,
    input  o_mem_wdata
  );

  modport slave (
    input  i_req,
    input  i_we,
    input  i_size,
    input  i_unsigned,
    input  i_addr,
    input  i_wdata,
    input  i_mem_rdata,
    output o_busy,
    output o_done,
    output o_rdata,
    output o_misalign,
    output o_mem_addr,
    output o_mem_re,
    output o_mem_we,
    output o_mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
// Purely combinational; low address bits below the access size are ignored.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        zext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{lane, 3'b000} +: 8];
    h      = lane[1] ? word[31:16] : word[15:0];
    load   = word;
    merged = wdata;
    unique case (size)
      SZ_BYTE: begin
        load   = zext ? {24'b0, b} : {{24{b[7]}}, b};
        merged = word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load   = zext ? {16'b0, h} : {{16{h[15]}}, h};
        merged = word;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load   = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store stage with read-modify-write for sub-word stores.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 32
) (
  input logic         i_clk,
  input logic         i_rst,
  mem_access_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);

  state_e            state;
  state_e            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic              we_q;
  logic              zext_q;
  logic [31:0]       rdata_q;
  logic [31:0]       wword_q;
  logic [31:0]       load;
  logic [31:0]       merged;
  logic              rd_last;
  logic              accept;
  logic              trap;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = is_misaligned(size_e'(bus.i_size), bus.i_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign rd_last = (cnt == LAT);
  assign accept  = (state == IDLE) && bus.i_req;

  mem_lane_align u_align (
    .size   (size_q),
    .lane   (addr_q[1:0]),
    .zext   (zext_q),
    .word   (bus.i_mem_rdata),
    .wdata  (wword_q),
    .load   (load),
    .merged (merged)
  );

  always_comb begin
    state_nx        = state;
    bus.o_busy      = (state != IDLE);
    bus.o_done      = (state == DONE);
    bus.o_mem_re    = (state == RD) && (cnt == '0);
    bus.o_mem_we    = (state == WR);
    bus.o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    bus.o_mem_wdata = wword_q;
    bus.o_rdata     = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    bus.o_misalign  = (state == DONE) && mis_q;
`else
    bus.o_misalign  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.i_req) begin
          if (trap)
            state_nx = DONE;
          else if (bus.i_we && is_word(size_e'(bus.i_size)))
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD: begin
        if (rd_last)
          state_nx = we_q ? WR : DONE;
      end
      WR:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      rdata_q <= '0;
      wword_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= (state == RD) ? cnt + 1'b1 : '0;
      if (accept) begin
        addr_q  <= bus.i_addr;
        size_q  <= size_e'(bus.i_size);
        we_q    <= bus.i_we;
        zext_q  <= bus.i_unsigned;
        wword_q <= bus.i_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_q   <= trap;
`endif
      end
      // Read data is only valid in the last RD cycle
      if ((state == RD) && rd_last) begin
        if (we_q)
          wword_q <= merged;
        else
          rdata_q <= load;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl with an arithmetic reference model.
// Honors MEM_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_access_ctrl;

  localparam int RD_LAT = 2;
  localparam int ADDR_W = 32;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    int          acc;
    int          re_cyc;
    int          we_cyc;
    int          done_cyc;
    logic [31:0] addr_al;
    logic [31:0] wword;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t        sbq[$];
  logic [31:0] ref_mem[16];
  logic [31:0] phys_mem[16];
  logic [31:0] last_rdata;
  int          rd_due = -1;
  logic [31:0] rd_word;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Memory: data appears RD_LAT cycles after the read strobe, junk otherwise
  always @(negedge clk) begin
    if (rst) begin
      rd_due = -1;
    end else if (bus.o_mem_re) begin
      rd_due  = cyc + RD_LAT;
      rd_word = phys_mem[bus.o_mem_addr[5:2]];
    end
    if (cyc == rd_due) bus.i_mem_rdata = rd_word;
    else               bus.i_mem_rdata = $urandom;
  end

  always @(negedge clk) begin : monitor
    exp_t f;
    bit   have;
    bit   ok;
    have = (sbq.size() > 0);
    if (have) f = sbq[0];
    if (!rst) begin
      if (bus.o_mem_re || (have && f.re_cyc == cyc)) begin
        checks++;
        ok = have && f.re_cyc == cyc && bus.o_mem_re &&
             bus.o_mem_addr == f.addr_al;
        if (!ok) begin
          errors++;
          $display("FAIL mem_re: cyc=%0d re=%0b addr=%h, want re at %0d addr=%h",
                   cyc, bus.o_mem_re, bus.o_mem_addr,
                   have ? f.re_cyc : -1, f.addr_al);
        end
      end
      if (bus.o_mem_we || (have && f.we_cyc == cyc)) begin
        checks++;
        ok = have && f.we_cyc == cyc && bus.o_mem_we &&
             bus.o_mem_addr == f.addr_al && bus.o_mem_wdata == f.wword;
        if (!ok) begin
          errors++;
          $display("FAIL mem_we: cyc=%0d we=%0b addr=%h data=%h, want we at %0d addr=%h data=%h",
                   cyc, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata,
                   have ? f.we_cyc : -1, f.addr_al, f.wword);
        end
        if (bus.o_mem_we)
          phys_mem[bus.o_mem_addr[5:2]] = bus.o_mem_wdata;
      end
      if (bus.o_done || (have && f.done_cyc == cyc)) begin
        checks++;
        ok = have && f.done_cyc == cyc && bus.o_done &&
             bus.o_rdata == f.rdata && bus.o_misalign == f.mis;
        if (!ok) begin
          errors++;
          $display("FAIL done: cyc=%0d done=%0b rdata=%h mis=%0b, want done at %0d rdata=%h mis=%0b",
                   cyc, bus.o_done, bus.o_rdata, bus.o_misalign,
                   have ? f.done_cyc : -1, f.rdata, f.mis);
        end
        if (have) void'(sbq.pop_front());
      end
    end
  end

  task automatic model(
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          acc,
    output exp_t        e
  );
    int          nb;
    int          off;
    int          idx;
    logic [31:0] mask;
    logic [31:0] v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = (int'(addr[1:0]) / nb) * nb;
    idx  = int'(addr[5:2]);
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    e.acc     = acc;
    e.addr_al = addr & ~32'd3;
    e.re_cyc  = -1;
    e.we_cyc  = -1;
    e.wword   = '0;
    e.mis     = 1'b0;
    e.rdata   = last_rdata;
    if (TRAP && (int'(addr[1:0]) % nb) != 0) begin
      e.mis      = 1'b1;
      e.done_cyc = acc + 1;
    end else if (!we) begin
      v = (ref_mem[idx] >> (8 * off)) & mask;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
      last_rdata = v;
      e.rdata    = v;
      e.re_cyc   = acc + 1;
      e.done_cyc = acc + 2 + RD_LAT;
    end else if (nb == 4) begin
      e.we_cyc     = acc + 1;
      e.done_cyc   = acc + 2;
      e.wword      = wd;
      ref_mem[idx] = wd;
    end else begin
      v = (ref_mem[idx] & ~(mask << (8 * off))) |
          ((wd & mask) << (8 * off));
      e.re_cyc     = acc + 1;
      e.we_cyc     = acc + 2 + RD_LAT;
      e.done_cyc   = acc + 3 + RD_LAT;
      e.wword      = v;
      ref_mem[idx] = v;
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got,
                           input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus.o_busy || bus.o_done || bus.o_rdata != 0 || bus.o_misalign ||
        bus.o_mem_addr != 0 || bus.o_mem_re || bus.o_mem_we ||
        bus.o_mem_wdata != 0) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b rdata=%h mis=%0b addr=%h re=%0b we=%0b wd=%h, want all 0",
               name, bus.o_busy, bus.o_done, bus.o_rdata, bus.o_misalign,
               bus.o_mem_addr, bus.o_mem_re, bus.o_mem_we, bus.o_mem_wdata);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sbq.size() != 0 || bus.o_busy) && n < 200);
    if (sbq.size() != 0 || bus.o_busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, want idle and 0 pending",
               bus.o_busy, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.i_we       = we;
    bus.i_size     = sz;
    bus.i_unsigned = uns;
    bus.i_addr     = addr;
    bus.i_wdata    = wd;
    bus.i_req      = 1'b1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    wait_idle();
    drive(we, sz, uns, addr, wd);
    model(we, sz, uns, addr, wd, cyc, e);
    sbq.push_back(e);
    @(negedge clk);
    #1;
    bus.i_req   = 1'b0;
    bus.i_wdata = $urandom;
    bus.i_addr  = $urandom;
  endtask

  task automatic hold_twice(input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd);
    exp_t e1;
    exp_t e2;
    wait_idle();
    drive(1'b1, sz, 1'b0, addr, wd);
    model(1'b1, sz, 1'b0, addr, wd, cyc, e1);
    sbq.push_back(e1);
    model(1'b1, sz, 1'b0, addr, wd, e1.done_cyc + 1, e2);
    sbq.push_back(e2);
    while (cyc <= e2.acc) begin
      @(negedge clk);
      #1;
    end
    bus.i_req = 1'b0;
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    ref_mem[idx]  = v;
    phys_mem[idx] = v;
  endtask

  initial begin : stim
    logic [31:0] save[16];
    logic [31:0] a;
    rst            = 1'b1;
    bus.i_req      = 1'b0;
    bus.i_we       = 1'b0;
    bus.i_size     = 2'd0;
    bus.i_unsigned = 1'b0;
    bus.i_addr     = '0;
    bus.i_wdata    = '0;
    last_rdata     = '0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    set_word(4, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    wait_idle();
    check_val("word_load", bus.o_rdata, 32'hDEADBEEF);

    set_word(4, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    wait_idle();
    check_val("byte_load_signed", bus.o_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    wait_idle();
    check_val("byte_load_unsigned", bus.o_rdata, 32'h00000080);

    set_word(8, 32'h11223344);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFFABCD);
    wait_idle();
    check_val("half_store_mem", phys_mem[8], 32'hABCD3344);
    check_val("store_keeps_rdata", bus.o_rdata, 32'h00000080);

    // Abort a byte store in its second cycle
    save = ref_mem;
    issue(1'b1, 2'b00, 1'b0, 32'h2D, 32'h5A);
    @(negedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    #1;
    check_zero("reset_mid_op");
    rst        = 1'b0;
    ref_mem    = save;
    last_rdata = '0;
    repeat (8) @(negedge clk);
    #1;
    check_val("reset_no_write", phys_mem[11], ref_mem[11]);
    issue(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0);
    wait_idle();
    check_val("post_reset_load", bus.o_rdata, ref_mem[11]);

    set_word(1, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    wait_idle();
`ifndef MEM_MISALIGN_TRAP_EN
    check_val("misaligned_forced", bus.o_rdata, 32'hCAFEF00D);
`endif
    issue(1'b0, 2'b01, 1'b1, 32'h07, 32'h0);
    wait_idle();

    hold_twice(2'b10, 32'h30, 32'h12345678);
    wait_idle();
    hold_twice(2'b00, 32'h35, 32'h000000EE);
    wait_idle();
    check_val("held_req_mem", phys_mem[13], ref_mem[13]);

    for (int n = 0; n < 150; n++) begin
      a = $urandom & 32'hF000_003F;
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    for (int i = 0; i < 16; i++)
      check_val($sformatf("mem_final[%0d]", i), phys_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
